// File: rtl/pc_source_pkg.sv
// Package for the PC-source unit: FSM state encoding, exception cause codes,
// the default exception vector base and a helper that turns a cause into a
// vector-table offset.
package pc_source_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EXC_CAPT  = 2'd1,
        ST_EXC_REDIR = 2'd2
    } pc_state_e;

    localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
    localparam logic [1:0] CAUSE_OVFL     = 2'd1;
    localparam logic [1:0] CAUSE_DIV0     = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

    localparam logic [31:0] EXC_VEC_BASE_DEF = 32'h0000_00F0;

    // Each vector-table entry is one 32-bit word, so the offset is 4*cause.
    function automatic logic [3:0] cause_offset(input logic [1:0] code);
        return {code, 2'b00};
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// N-way next-PC selector. Source i lives at src_data_i[i*DATA_W +: DATA_W];
// a selector value with no matching source yields zero, matching the
// behaviour of the original fixed-width PC-source mux.
module pc_src_mux #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [SEL_W-1:0]          src_sel_i,
    output logic [DATA_W-1:0]         next_pc_o
);

    // Select the addressed source, defaulting to zero for out-of-range selects.
    always_comb begin
        next_pc_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel_i == SEL_W'(i)) begin
                next_pc_o = src_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// PC-source unit: owns the architectural PC, selects the next PC from
// NUM_SRC sources, gates unconditional/conditional writes and runs a
// two-cycle exception entry (capture EPC/cause, then redirect to the vector).
// Optional feature: define PC_ALIGN_CHECK_EN to trap writes of misaligned
// targets as cause CAUSE_MISALIGN instead of writing them verbatim.
module pc_source_unit
    import pc_source_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                NUM_SRC      = 4,
    parameter int                SEL_W        = $clog2(NUM_SRC),
    parameter logic [DATA_W-1:0] RESET_PC     = '0,
    parameter logic [DATA_W-1:0] EXC_VEC_BASE = DATA_W'(EXC_VEC_BASE_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      pc_write,
    input  logic                      pc_write_cond,
    input  logic                      cond_true,
    input  logic                      exc_req,
    input  logic [1:0]                exc_code,
    output logic [DATA_W-1:0]         pc,
    output logic [DATA_W-1:0]         epc,
    output logic [1:0]                cause,
    output logic                      exc_busy,
    output logic                      exc_taken
);

    pc_state_e         state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [1:0]        cause_q, cause_d;
    logic [1:0]        req_code_q, req_code_d;

    logic [DATA_W-1:0] next_pc;
    logic              wr_en;

    pc_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_data_i (src_data),
        .src_sel_i  (src_sel),
        .next_pc_o  (next_pc)
    );

    assign wr_en = pc_write | (pc_write_cond & cond_true);

    // Next-state and datapath update; requests arriving while busy are dropped.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        req_code_d = req_code_q;
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    // Exception wins over any simultaneous PC write.
                    state_d    = ST_EXC_CAPT;
                    req_code_d = exc_code;
                end
`ifdef PC_ALIGN_CHECK_EN
                else if (wr_en && (next_pc[1:0] != 2'b00)) begin
                    state_d    = ST_EXC_CAPT;
                    req_code_d = CAUSE_MISALIGN;
                end
`endif
                else if (wr_en) begin
                    pc_d = next_pc;
                end
            end
            ST_EXC_CAPT: begin
                // PC was already advanced at fetch; the faulting instruction is one word back.
                epc_d   = pc_q - DATA_W'(4);
                cause_d = req_code_q;
                state_d = ST_EXC_REDIR;
            end
            ST_EXC_REDIR: begin
                pc_d    = EXC_VEC_BASE + DATA_W'(cause_offset(cause_q));
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            cause_q    <= '0;
            req_code_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            req_code_q <= req_code_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign cause     = cause_q;
    assign exc_busy  = (state_q != ST_RUN);
    assign exc_taken = (state_q == ST_EXC_REDIR);

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed testbench for pc_source_unit. NUM_SRC=5 so the selector is three
// bits wide and out-of-range selects (5..7) can be exercised.
// Expectations for the misaligned-write case follow PC_ALIGN_CHECK_EN.
module tb_pc_source_unit;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = $clog2(NUM_SRC);

    logic                      clk;
    logic                      reset;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          src_sel;
    logic                      pc_write;
    logic                      pc_write_cond;
    logic                      cond_true;
    logic                      exc_req;
    logic [1:0]                exc_code;
    logic [DATA_W-1:0]         pc;
    logic [DATA_W-1:0]         epc;
    logic [1:0]                cause;
    logic                      exc_busy;
    logic                      exc_taken;

    int checks;
    int errors;
    int taken_cnt;

    pc_source_unit #(
        .DATA_W       (DATA_W),
        .NUM_SRC      (NUM_SRC),
        .RESET_PC     (32'h0),
        .EXC_VEC_BASE (32'h0000_00F0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_data      (src_data),
        .src_sel       (src_sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_true     (cond_true),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .pc            (pc),
        .epc           (epc),
        .cause         (cause),
        .exc_busy      (exc_busy),
        .exc_taken     (exc_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exc_taken) taken_cnt++;
    endtask

    task automatic set_src(input int idx, input logic [31:0] val);
        src_data[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        taken_cnt     = 0;
        reset         = 1'b1;
        src_data      = '0;
        src_sel       = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        cond_true     = 1'b0;
        exc_req       = 1'b0;
        exc_code      = 2'd0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_cause", 32'(cause), 32'h0);
        check("rst_busy", 32'(exc_busy), 32'h0);
        check("rst_taken", 32'(exc_taken), 32'h0);

        // Reset in the middle of exception capture.
        reset    = 1'b0;
        exc_req  = 1'b1;
        exc_code = 2'd2;
        tick();
        check("capt_busy", 32'(exc_busy), 32'h1);
        exc_req = 1'b0;
        reset   = 1'b1;
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_epc", epc, 32'h0);
        check("mid_rst_cause", 32'(cause), 32'h0);
        check("mid_rst_busy", 32'(exc_busy), 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(exc_busy), 32'h0);
        check("post_rst_taken", 32'(exc_taken), 32'h0);

        // Unconditional writes and out-of-range selects.
        set_src(1, 32'h40);
        src_sel  = 3'd1;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        check("wr_src1", pc, 32'h40);
        tick();
        check("no_wr_hold", pc, 32'h40);
        src_sel  = 3'd5;
        pc_write = 1'b1;
        tick();
        check("sel5_zero", pc, 32'h0);
        src_sel = 3'd1;
        tick();
        check("wr_src1_again", pc, 32'h40);
        src_sel = 3'd7;
        tick();
        pc_write = 1'b0;
        check("sel7_zero", pc, 32'h0);

        // Conditional writes.
        set_src(0, 32'h84);
        src_sel       = 3'd0;
        pc_write_cond = 1'b1;
        cond_true     = 1'b0;
        tick();
        check("cond_false", pc, 32'h0);
        cond_true = 1'b1;
        tick();
        check("cond_true", pc, 32'h84);
        pc_write_cond = 1'b0;
        cond_true     = 1'b0;

        // Exception wins over a simultaneous write.
        set_src(2, 32'h108);
        src_sel  = 3'd2;
        pc_write = 1'b1;
        tick();
        check("pc_108", pc, 32'h108);
        src_sel  = 3'd0;
        exc_req  = 1'b1;
        exc_code = 2'd1;
        tick();
        check("exc_pc_held", pc, 32'h108);
        check("exc_busy", 32'(exc_busy), 32'h1);
        exc_req  = 1'b0;
        pc_write = 1'b0;
        exc_code = 2'd3;
        tick();
        check("exc_epc", epc, 32'h104);
        check("exc_cause", 32'(cause), 32'h1);
        check("exc_taken", 32'(exc_taken), 32'h1);
        check("exc_pc_still", pc, 32'h108);
        tick();
        check("exc_vec", pc, 32'hF4);
        check("exc_taken_off", 32'(exc_taken), 32'h0);
        check("exc_busy_off", 32'(exc_busy), 32'h0);

        // Requests and writes during busy are dropped.
        taken_cnt = 0;
        exc_req   = 1'b1;
        exc_code  = 2'd2;
        tick();
        pc_write = 1'b1;
        src_sel  = 3'd1;
        exc_code = 2'd0;
        tick();
        check("busy_epc", epc, 32'h0F0);
        check("busy_cause", 32'(cause), 32'h2);
        tick();
        exc_req  = 1'b0;
        pc_write = 1'b0;
        check("busy_vec", pc, 32'hF8);
        tick();
        check("busy_pc_after", pc, 32'hF8);
        check("busy_idle", 32'(exc_busy), 32'h0);
        check("taken_once", 32'(taken_cnt), 32'h1);

        // epc wraps when pc is zero.
        src_sel  = 3'd5;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        check("pc_zero", pc, 32'h0);
        exc_req  = 1'b1;
        exc_code = 2'd0;
        tick();
        exc_req = 1'b0;
        tick();
        check("wrap_epc", epc, 32'hFFFF_FFFC);
        check("wrap_cause", 32'(cause), 32'h0);
        tick();
        check("wrap_vec", pc, 32'hF0);

        // Misaligned target.
        set_src(3, 32'h42);
        src_sel  = 3'd3;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc_held", pc, 32'hF0);
        check("mis_busy", 32'(exc_busy), 32'h1);
        tick();
        check("mis_cause", 32'(cause), 32'h3);
        check("mis_epc", epc, 32'hEC);
        tick();
        check("mis_vec", pc, 32'hFC);
`else
        check("mis_pc", pc, 32'h42);
        check("mis_busy", 32'(exc_busy), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
